// File: rtl/datamem_arbiter_pkg.sv
// Shared constants and types for the two-port data memory arbiter.
// Port identifiers, burst counter type, default widths and the address range check.
package datamem_arb_pkg;

    localparam logic PORT_CPU   = 1'b0;
    localparam logic PORT_DMA   = 1'b1;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 8;
    localparam int ADDR_BUS_W   = 32;
    localparam int BURST_W      = 8;

    typedef logic [BURST_W-1:0] burst_cnt_t;

    // An address is legal only when every bit above the implemented index is zero.
    function automatic logic in_range(input logic [ADDR_BUS_W-1:0] addr, input int aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/datamem_arbiter_if.sv
// Requester and memory-side signal bundle for datamem_arbiter.
// slave = arbiter view, master = requester/memory view.
interface datamem_arbiter_if
    import datamem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_BUS_W-1:0] addr0;
    logic [ADDR_BUS_W-1:0] addr1;
    logic [DATA_W-1:0]     wdata0;
    logic [DATA_W-1:0]     wdata1;

    logic                  gnt0;
    logic                  gnt1;
    logic [DATA_W-1:0]     rdata0;
    logic [DATA_W-1:0]     rdata1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic                  err0;
    logic                  err1;

    logic [ADDR_BUS_W-1:0] mem_address;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_W-1:0]     mem_din;
    logic [DATA_W-1:0]     mem_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, err0, err1,
               mem_address, mem_write, mem_read, mem_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, err0, err1,
               mem_address, mem_write, mem_read, mem_din
    );

endinterface

// File: rtl/datamem_arbiter_rr_pick2.sv
// Two-way round-robin pick with burst cap; purely combinational, zero latency.
// A losing requester simply sees no win and must keep requesting.
module rr_pick2
    import datamem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_owner,
    input  burst_cnt_t burst_cnt,
    output logic       winner,
    output logic       valid
);

    localparam burst_cnt_t CNT_MAX = burst_cnt_t'(MAX_BURST - 1);

    always_comb begin
        winner = PORT_CPU;
        valid  = req0 | req1;
        if (req0 && req1) begin
            winner = (burst_cnt < CNT_MAX) ? last_owner : ~last_owner;
        end else if (req1) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Shares one data memory between CPU (port 0) and DMA (port 1): one access per cycle.
// Grant is combinational; read data/err return one cycle later; losers hold their request.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    datamem_arbiter_if.slave bus
);

    localparam burst_cnt_t CNT_MAX = burst_cnt_t'(MAX_BURST - 1);

    logic                  last_owner;
    burst_cnt_t            burst_cnt;
    logic                  fresh;
    burst_cnt_t            cnt_view;
    logic                  winner;
    logic                  win_vld;
    logic                  active;

    logic                  sel_we;
    logic [ADDR_BUS_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  sel_ok;

    logic                  rd_go0;
    logic                  rd_go1;
    logic                  err_go0;
    logic                  err_go1;

    logic [DATA_W-1:0]     rdata0_q;
    logic [DATA_W-1:0]     rdata1_q;
    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic                  err0_q;
    logic                  err1_q;

    // Out of reset last_owner is port 1; presenting a saturated count hands the first tie to port 0.
    assign cnt_view = fresh ? CNT_MAX : burst_cnt;

    rr_pick2 #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_owner (last_owner),
        .burst_cnt  (cnt_view),
        .winner     (winner),
        .valid      (win_vld)
    );

    always_comb begin
        sel_we    = bus.we0;
        sel_addr  = bus.addr0;
        sel_wdata = bus.wdata0;
        if (winner == PORT_DMA) begin
            sel_we    = bus.we1;
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
        end
    end

    assign sel_ok = in_range(sel_addr, ADDR_W);
    assign active = win_vld & rst_n;

    assign bus.gnt0        = active & (winner == PORT_CPU);
    assign bus.gnt1        = active & (winner == PORT_DMA);
    assign bus.mem_address = active ? ADDR_BUS_W'(sel_addr[ADDR_W-1:0]) : '0;
    assign bus.mem_write   = active & sel_ok & sel_we;
    assign bus.mem_read    = active & sel_ok & ~sel_we;
    assign bus.mem_din     = active ? sel_wdata : '0;

    assign rd_go0  = win_vld & (winner == PORT_CPU) & sel_ok & ~sel_we;
    assign rd_go1  = win_vld & (winner == PORT_DMA) & sel_ok & ~sel_we;
    assign err_go0 = win_vld & (winner == PORT_CPU) & ~sel_ok;
    assign err_go1 = win_vld & (winner == PORT_DMA) & ~sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= PORT_DMA;
            burst_cnt  <= '0;
            fresh      <= 1'b1;
        end else if (win_vld) begin
            fresh <= 1'b0;
            if (winner == last_owner) begin
                if (burst_cnt < CNT_MAX) begin
                    burst_cnt <= burst_cnt + burst_cnt_t'(1);
                end
            end else begin
                last_owner <= winner;
                burst_cnt  <= '0;
            end
        end else begin
            burst_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            rvalid0_q <= rd_go0;
            rvalid1_q <= rd_go1;
            err0_q    <= err_go0;
            err1_q    <= err_go1;
            if (rd_go0) begin
                rdata0_q <= bus.mem_dout;
            end
            if (rd_go1) begin
                rdata1_q <= bus.mem_dout;
            end
        end
    end

    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: scripted scenarios plus randomized traffic against a
// transaction-level model (grant runs, word-array memory, expected return pulses).
module tb_datamem_arbiter;
    import datamem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    datamem_arbiter_if #(.DATA_W(DW)) bus  ();
    datamem_arbiter_if #(.DATA_W(DW)) bus1 ();

    datamem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    datamem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    logic [DW-1:0] mem [256] = '{default: '0};
    assign bus.mem_dout  = mem[bus.mem_address[AW-1:0]];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[AW-1:0]] <= bus.mem_din;
    assign bus1.mem_dout = bus1.mem_address ^ 32'hA5A5_A5A5;

    // Reference model state
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    int            m_last;
    int            m_run;
    bit            m_first;
    int            exp_w;
    bit            p_req   [2];
    bit            p_we    [2];
    logic [31:0]   p_addr  [2];
    logic [DW-1:0] p_wdata [2];
    bit            e_mw, e_mr;
    logic [31:0]   e_maddr;
    logic [DW-1:0] e_mdin;
    logic [DW-1:0] e_rdata [2];
    bit            e_rvalid [2];
    bit            e_err    [2];

    int n_vec = 0;
    int n_bad = 0;

    task automatic model_reset();
        m_last   = 1;
        m_run    = 1;
        m_first  = 1;
        e_rdata  = '{'0, '0};
        e_rvalid = '{0, 0};
        e_err    = '{0, 0};
    endtask

    // Tie rule: the last owner keeps the memory until it has had MB grants in a row.
    task automatic predict();
        if (p_req[0] && p_req[1]) begin
            if (m_first)        exp_w = 0;
            else if (m_run < MB) exp_w = m_last;
            else                exp_w = 1 - m_last;
        end else if (p_req[0]) exp_w = 0;
        else if (p_req[1])     exp_w = 1;
        else                   exp_w = -1;
        e_mw = 0; e_mr = 0; e_maddr = '0; e_mdin = '0;
        if (exp_w >= 0) begin
            e_maddr = p_addr[exp_w] % 32'(2**AW);
            e_mdin  = p_wdata[exp_w];
            if (p_addr[exp_w] < 32'(2**AW)) begin
                e_mw = p_we[exp_w];
                e_mr = !p_we[exp_w];
            end
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [DW-1:0] d0,
                         input bit r1, input bit w1, input logic [31:0] a1, input logic [DW-1:0] d1);
        p_req = '{r0, r1}; p_we = '{w0, w1}; p_addr = '{a0, a1}; p_wdata = '{d0, d1};
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        #2;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            e_rvalid = '{0, 0};
            e_err    = '{0, 0};
            if (exp_w >= 0) begin
                if (p_addr[exp_w] >= 32'(2**AW)) e_err[exp_w] = 1;
                else if (p_we[exp_w]) ref_mem[p_addr[exp_w]] = p_wdata[exp_w];
                else begin
                    e_rdata[exp_w]  = ref_mem[p_addr[exp_w]];
                    e_rvalid[exp_w] = 1;
                end
                if (exp_w == m_last) m_run++;
                else begin m_last = exp_w; m_run = 1; end
                m_first = 0;
            end else begin
                m_run = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 0, 32'd3, '0, 1, 1, 32'd4, 32'h1);
        n_vec++;
        if ({bus.gnt0, bus.gnt1, bus.mem_write, bus.mem_read} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_gnt: got %b want 0000", {bus.gnt0, bus.gnt1, bus.mem_write, bus.mem_read});
        end
        tick();
        n_vec++;
        if ({bus.rvalid0, bus.rvalid1, bus.err0, bus.err1} !== 4'b0000 || bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
            n_bad++; $display("FAIL reset_ret: got v/e %b rd %h %h want 0", {bus.rvalid0, bus.rvalid1, bus.err0, bus.err1}, bus.rdata0, bus.rdata1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        drive(1, 1, 32'd5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        n_vec++;
        if ({bus.gnt0, bus.gnt1, bus.mem_write} !== 3'b101 || bus.mem_address !== 32'd5 || bus.mem_din !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL wr_grant: got g/w %b addr %h din %h want 101 5 deadbeef", {bus.gnt0, bus.gnt1, bus.mem_write}, bus.mem_address, bus.mem_din);
        end
        tick();
        drive(0, 0, 0, 0, 1, 0, 32'd5, 0);
        n_vec++;
        if ({bus.gnt0, bus.gnt1, bus.mem_read} !== 3'b011) begin
            n_bad++; $display("FAIL rd_grant: got %b want 011", {bus.gnt0, bus.gnt1, bus.mem_read});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL raw_data: got v %b d %h want 1 deadbeef", bus.rvalid1, bus.rdata1);
        end
        tick();
        n_vec++;
        if (bus.rvalid1 !== 1'b0) begin
            n_bad++; $display("FAIL rvalid_pulse: got %b want 0", bus.rvalid1);
        end
    endtask

    task automatic test_round_robin();
        int pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 32'd7, 0, 1, 0, 32'd9, 0);
            n_vec++;
            if ({bus.gnt0, bus.gnt1} !== {pat[i] == 0, pat[i] == 1}) begin
                n_bad++; $display("FAIL rr_cycle%0d: got %b%b want port %0d", i, bus.gnt0, bus.gnt1, pat[i]);
            end
            tick();
            n_vec++;
            if ({bus.rvalid0, bus.rvalid1} !== {e_rvalid[0], e_rvalid[1]} || bus.rdata0 !== e_rdata[0] || bus.rdata1 !== e_rdata[1]) begin
                n_bad++; $display("FAIL rr_ret%0d: got %b%b %h %h want %b%b %h %h", i, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
                                  e_rvalid[0], e_rvalid[1], e_rdata[0], e_rdata[1]);
            end
        end
    endtask

    task automatic test_single_port();
        logic [DW-1:0] vals [3];
        for (int k = 0; k < 3; k++) begin
            vals[k] = $urandom;
            drive(1, 1, 32'(k + 1), vals[k], 0, 0, 0, 0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 0, 32'(k + 1), 0);
            n_vec++;
            if (bus.gnt1 !== 1'b1) begin
                n_bad++; $display("FAIL single_gnt%0d: got %b want 1", k, bus.gnt1);
            end
            tick();
            n_vec++;
            if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== vals[k]) begin
                n_bad++; $display("FAIL single_data%0d: got %b %h want 1 %h", k, bus.rvalid1, bus.rdata1, vals[k]);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_out_of_range();
        drive(0, 0, 0, 0, 1, 1, 32'd0, 32'h1234_5678);
        tick();
        drive(1, 1, 32'h100, 32'hBAD0_BAD0, 0, 0, 0, 0);
        n_vec++;
        if ({bus.gnt0, bus.mem_write, bus.mem_read} !== 3'b100) begin
            n_bad++; $display("FAIL oor_grant: got %b want 100", {bus.gnt0, bus.mem_write, bus.mem_read});
        end
        tick();
        drive(0, 0, 0, 0, 1, 0, 32'd0, 0);
        n_vec++;
        if ({bus.err0, bus.rvalid0} !== 2'b10) begin
            n_bad++; $display("FAIL oor_err: got %b want 10", {bus.err0, bus.rvalid0});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.err0 !== 1'b0 || bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'h1234_5678) begin
            n_bad++; $display("FAIL oor_mem0: got err %b v %b d %h want 0 1 12345678", bus.err0, bus.rvalid1, bus.rdata1);
        end
        tick();
    endtask

    task automatic test_alternate();
        bus1.req0 = 1'b1; bus1.we0 = 1'b0; bus1.addr0 = 32'd1;
        bus1.req1 = 1'b1; bus1.we1 = 1'b0; bus1.addr1 = 32'd2;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            n_vec++;
            if ({bus1.gnt0, bus1.gnt1} !== {i % 2 == 0, i % 2 == 1}) begin
                n_bad++; $display("FAIL alt_cycle%0d: got %b%b want port %0d", i, bus1.gnt0, bus1.gnt1, i % 2);
            end
            tick();
        end
        bus1.req0 = 1'b0; bus1.req1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 32'd2, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 32'd3, 0, 0, 0, 0, 0);
        n_vec++;
        if ({bus.rvalid0, bus.gnt0, bus.mem_read} !== 3'b111) begin
            n_bad++; $display("FAIL mid_pre: got %b want 111", {bus.rvalid0, bus.gnt0, bus.mem_read});
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.rvalid0, bus.gnt0, bus.mem_read} !== 3'b000) begin
            n_bad++; $display("FAIL mid_async: got %b want 000", {bus.rvalid0, bus.gnt0, bus.mem_read});
        end
        tick();
        rst_n = 1'b1;
        drive(1, 0, 32'd5, 0, 1, 0, 32'd6, 0);
        n_vec++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            n_bad++; $display("FAIL mid_tie: got %b want 10", {bus.gnt0, bus.gnt1});
        end
        tick();
        n_vec++;
        if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== e_rdata[0]) begin
            n_bad++; $display("FAIL mid_reissue: got %b %h want 1 %h", bus.rvalid0, bus.rdata0, e_rdata[0]);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        bit            r [2];
        bit            w [2];
        logic [31:0]   a [2];
        logic [DW-1:0] d [2];
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (p_req[p] && exp_w != p) begin
                    r[p] = p_req[p]; w[p] = p_we[p]; a[p] = p_addr[p]; d[p] = p_wdata[p];
                end else begin
                    r[p] = ($urandom_range(0, 9) < 7);
                    w[p] = $urandom_range(0, 1) == 1;
                    a[p] = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 15));
                    d[p] = $urandom;
                end
            end
            drive(r[0], w[0], a[0], d[0], r[1], w[1], a[1], d[1]);
            n_vec++;
            if ({bus.gnt0, bus.gnt1, bus.mem_write, bus.mem_read} !== {exp_w == 0, exp_w == 1, e_mw, e_mr} ||
                bus.mem_address !== e_maddr || (e_mw && bus.mem_din !== e_mdin)) begin
                n_bad++; $display("FAIL rand_req%0d: got g%b%b w%b r%b a%h d%h want g%b%b w%b r%b a%h d%h", i,
                                  bus.gnt0, bus.gnt1, bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_din,
                                  exp_w == 0, exp_w == 1, e_mw, e_mr, e_maddr, e_mdin);
            end
            tick();
            n_vec++;
            if ({bus.rvalid0, bus.rvalid1, bus.err0, bus.err1} !== {e_rvalid[0], e_rvalid[1], e_err[0], e_err[1]} ||
                bus.rdata0 !== e_rdata[0] || bus.rdata1 !== e_rdata[1]) begin
                n_bad++; $display("FAIL rand_ret%0d: got %b %h %h want %b %h %h", i,
                                  {bus.rvalid0, bus.rvalid1, bus.err0, bus.err1}, bus.rdata0, bus.rdata1,
                                  {e_rvalid[0], e_rvalid[1], e_err[0], e_err[1]}, e_rdata[0], e_rdata[1]);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        bus1.req0 = 1'b0; bus1.we0 = 1'b0; bus1.addr0 = '0; bus1.wdata0 = '0;
        bus1.req1 = 1'b0; bus1.we1 = 1'b0; bus1.addr1 = '0; bus1.wdata1 = '0;
        exp_w = -1;
        model_reset();
        test_reset();
        test_write_read();
        test_round_robin();
        test_single_port();
        test_out_of_range();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
